// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg
//   Shared definitions for the programmable sequence detector controller:
//   controller state encoding and the configuration loaded at reset.
package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Configuration after reset: detect "0011", non-overlapping.
    localparam logic [3:0] RST_PATTERN = 4'b0011;
    localparam int         RST_LEN     = 4;
    localparam logic       RST_OVERLAP = 1'b0;

endpackage

// File: rtl/seq_matcher.sv
// seq_matcher
//   Serial pattern matcher: keeps the most recent input bits in a shift
//   register plus a count of how many of them may still take part in a match,
//   and compares them together with the bit currently on 'in' against the
//   configured pattern.
// Ports
//   clock, reset  rising-edge clock, synchronous active-high reset
//   clear         empty the history (new detection window)
//   shift         consume 'in' this cycle; also qualifies 'match'
//   in            serial data bit
//   pattern/len   pattern (bit len-1 received first) and its length
//   overlap       1 = bits of a match may be reused by the next match
//   match         combinational: 'in' completes the pattern this cycle
module seq_matcher
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift,
    input  logic             in,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             overlap,
    output logic             match
);

    logic [PAT_W-1:0] history;
    logic [LEN_W-1:0] valid;    // usable history bits, saturates at PAT_W
    logic [PAT_W:0]   seq;
    logic [PAT_W-1:0] mask;
    logic             enough;

    // NOTE: every variable written here gets a value before any conditional
    // use, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        seq  = {history, in};
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len));
        end
        // history bits plus the live bit must cover the whole pattern
        enough = ({1'b0, valid} + (LEN_W+1)'(1)) >= {1'b0, len};
        match  = shift && enough && ((seq[PAT_W-1:0] & mask) == (pattern & mask));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            history <= '0;
            valid   <= '0;
        end else if (shift) begin
            history <= seq[PAT_W-1:0];
            if (match && !overlap) begin
                valid <= '0;                 // matched bits are used up
            end else if (valid < LEN_W'(PAT_W)) begin
                valid <= valid + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
//   Programmable controller around seq_matcher. Holds the pattern
//   configuration, runs a detection window of 'window' bits after 'start',
//   raises a same-cycle Mealy match on 'out', counts matches (saturating)
//   and pulses 'done' when the window ends.
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in                    serial data bit, consumed once per cycle in RUN
//   cfg_we, cfg_pattern,  configuration write (accepted in IDLE/DONE with
//   cfg_len, cfg_overlap  1 <= cfg_len <= PAT_W)
//   start, window         begin a window of 'window' bits (IDLE only)
//   abort                 end the window early without 'done'
//   out                   match pulse, combinational from 'in'
//   busy, done            in RUN / one-cycle window-end pulse
//   match_cnt             matches in current/last window
//   cfg_err               sticky flag for a rejected configuration write
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int WIN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             start,
    input  logic [WIN_W-1:0] window,
    input  logic             abort,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cfg_err
);

    state_t           state, state_nxt;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic             overlap;
    logic [WIN_W-1:0] remaining;
    logic             start_acc;
    logic             consume;
    logic             cfg_legal;
    logic             match;

    always_comb begin
        start_acc = (state == IDLE) && start && !abort;   // abort beats start
        consume   = (state == RUN) && !abort;
        cfg_legal = (cfg_len != '0) && (int'(cfg_len) <= PAT_W);
        busy      = (state == RUN);
        done      = (state == DONE);
        out       = match;
        state_nxt = state;
        case (state)
            IDLE: if (start_acc) state_nxt = (window == '0) ? DONE : RUN;
            RUN: begin
                if (abort)                           state_nxt = IDLE;
                else if (remaining == WIN_W'(1))     state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Configuration only changes outside RUN; the matcher first uses it on
    // the cycle after START, so a write together with START takes effect.
    always_ff @(posedge clock) begin
        if (reset) begin
            pattern <= PAT_W'(RST_PATTERN);
            len     <= LEN_W'(RST_LEN);
            overlap <= RST_OVERLAP;
            cfg_err <= 1'b0;
        end else if (cfg_we) begin
            if (state != RUN && cfg_legal) begin
                pattern <= cfg_pattern;
                len     <= cfg_len;
                overlap <= cfg_overlap;
                cfg_err <= 1'b0;
            end else begin
                cfg_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            remaining <= '0;
            match_cnt <= '0;
        end else if (start_acc) begin
            remaining <= window;
            match_cnt <= '0;
        end else if (consume) begin
            remaining <= remaining - WIN_W'(1);
            if (match && match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
        end
    end

    seq_matcher #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_matcher (
        .clock   (clock),
        .reset   (reset),
        .clear   (start_acc),
        .shift   (consume),
        .in      (in),
        .pattern (pattern),
        .len     (len),
        .overlap (overlap),
        .match   (match)
    );

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl
//   Drives two controllers (CNT_W=8 and CNT_W=2) with the same stimulus and
//   compares both against a bit-list reference model of the detector.
module tb_seq_detect_ctrl;

    logic       clock = 1'b0;
    logic       reset, in, cfg_we, cfg_overlap, start, abort;
    logic [7:0] cfg_pattern, window;
    logic [3:0] cfg_len;
    logic       out, busy, done, cfg_err;
    logic [7:0] match_cnt;
    logic       out2, busy2, done2, cfg_err2;
    logic [1:0] match_cnt2;
    logic [17:0] act;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: configuration, phase, bits consumed this window.
    int         m_mode = 0;          // 0 idle, 1 running, 2 window ended
    int         m_left = 0;
    int         m_cnt  = 0;
    int         m_from = 0;          // first bit index still usable for a match
    int         m_len  = 4;
    logic [7:0] m_pat  = 8'h03;
    logic       m_ovl  = 1'b0;
    logic       m_err  = 1'b0;
    logic       bits[$];

    always #5 clock = ~clock;

    assign act = {out, busy, done, match_cnt, cfg_err,
                  out2, busy2, done2, match_cnt2, cfg_err2};

    seq_detect_ctrl #(.PAT_W(8), .LEN_W(4), .WIN_W(8), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .in(in), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .start(start), .window(window), .abort(abort), .out(out), .busy(busy),
        .done(done), .match_cnt(match_cnt), .cfg_err(cfg_err));

    seq_detect_ctrl #(.PAT_W(8), .LEN_W(4), .WIN_W(8), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .in(in), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .start(start), .window(window), .abort(abort), .out(out2), .busy(busy2),
        .done(done2), .match_cnt(match_cnt2), .cfg_err(cfg_err2));

    // Does the bit on 'in' complete the pattern from the usable bits so far?
    function automatic logic exp_match();
        int n;
        if (m_mode != 1 || abort) return 1'b0;
        n = bits.size();
        if (n + 1 - m_from < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (((i == 0) ? in : bits[n - i]) !== m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [17:0] exp_vec();
        logic m;
        int   c8, c2;
        m  = exp_match();
        c8 = (m_cnt > 255) ? 255 : m_cnt;
        c2 = (m_cnt > 3) ? 3 : m_cnt;
        return {m, m_mode == 1, m_mode == 2, 8'(c8), m_err,
                m, m_mode == 1, m_mode == 2, 2'(c2), m_err};
    endfunction

    // Advance one clock; the model takes the same inputs the DUT samples.
    task automatic tick();
        logic m;
        m = exp_match();
        @(posedge clock);
        if (reset) begin
            m_mode = 0; m_cnt = 0; m_err = 1'b0; m_pat = 8'h03; m_len = 4;
            m_ovl = 1'b0; m_from = 0; bits.delete();
        end else begin
            if (cfg_we) begin
                if (m_mode == 1 || cfg_len == 0 || cfg_len > 8) m_err = 1'b1;
                else begin
                    m_pat = cfg_pattern; m_len = int'(cfg_len);
                    m_ovl = cfg_overlap; m_err = 1'b0;
                end
            end
            case (m_mode)
                0: if (start && !abort) begin
                    m_cnt = 0; m_from = 0; bits.delete();
                    m_left = int'(window);
                    m_mode = (window == 0) ? 2 : 1;
                end
                1: if (abort) m_mode = 0;
                   else begin
                       bits.push_back(in);
                       if (m) begin
                           m_cnt++;
                           if (!m_ovl) m_from = bits.size();
                       end
                       m_left--;
                       if (m_left == 0) m_mode = 2;
                   end
                default: m_mode = 0;
            endcase
        end
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        reset = 1'b0; in = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; start = 1'b0; window = '0; abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        #1;
        vectors++;
        if (act !== exp_vec()) begin
            miscompares++; $display("FAIL reset_model: dut %b model %b", act, exp_vec());
        end
        vectors++;
        if (act !== 18'b0) begin
            miscompares++; $display("FAIL reset_zero: dut %b required all zero", act);
        end
        reset = 1'b0;
    endtask

    task automatic test_default_pattern();
        logic [9:0] stream = 10'b0011000011;   // first bit is stream[9]
        int         busy_cycles = 0;
        start = 1'b1; window = 8'd10; in = 1'b0;
        #1;
        vectors++;
        if (act !== exp_vec()) begin
            miscompares++; $display("FAIL default_start: dut %b model %b", act, exp_vec());
        end
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in = stream[9-k];
            #1;
            vectors++;
            if (act !== exp_vec()) begin
                miscompares++; $display("FAIL default_bit%0d: dut %b model %b", k, act, exp_vec());
            end
            vectors++;
            if (out !== (k == 3 || k == 9)) begin
                miscompares++; $display("FAIL default_out%0d: dut %b required %b", k, out, (k == 3 || k == 9));
            end
            if (busy) busy_cycles++;
            tick();
        end
        #1;
        vectors++;
        if (done !== 1'b1 || match_cnt !== 8'd2 || busy_cycles != 10) begin
            miscompares++;
            $display("FAIL default_end: done %b cnt %0d busy_cycles %0d required 1 2 10", done, match_cnt, busy_cycles);
        end
        tick();
        #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || match_cnt !== 8'd2) begin
            miscompares++; $display("FAIL default_hold: done %b busy %b cnt %0d required 0 0 2", done, busy, match_cnt);
        end
    endtask

    task automatic test_cfg_err();
        start = 1'b1; window = 8'd4; in = 1'b0;
        tick();
        start = 1'b0;
        cfg_we = 1'b1; cfg_pattern = 8'hA5; cfg_len = 4'd3; cfg_overlap = 1'b1; in = 1'b0;
        #1;
        vectors++;
        if (act !== exp_vec()) begin
            miscompares++; $display("FAIL cfg_run_write: dut %b model %b", act, exp_vec());
        end
        tick();
        cfg_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in = (k > 0);
            #1;
            vectors++;
            if (act !== exp_vec()) begin
                miscompares++; $display("FAIL cfg_run_bit%0d: dut %b model %b", k, act, exp_vec());
            end
            tick();
        end
        #1;
        vectors++;
        if (cfg_err !== 1'b1 || done !== 1'b1 || match_cnt !== 8'd1) begin
            miscompares++; $display("FAIL cfg_run_kept: err %b done %b cnt %0d required 1 1 1", cfg_err, done, match_cnt);
        end
        // alternate legal writes (restoring defaults) with illegal lengths 0 and 9
        for (int k = 0; k < 4; k++) begin
            cfg_we = 1'b1; cfg_pattern = 8'h03; cfg_overlap = 1'b0;
            cfg_len = (k == 1) ? 4'd0 : (k == 3) ? 4'd9 : 4'd4;
            tick();
            cfg_we = 1'b0;
            #1;
            vectors++;
            if (act !== exp_vec() || cfg_err !== k[0]) begin
                miscompares++; $display("FAIL cfg_len%0d: dut %b model %b err_req %b", cfg_len, act, exp_vec(), k[0]);
            end
        end
        cfg_we = 1'b1; cfg_len = 4'd4;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic test_abort();
        logic [4:0] stream = 5'b00110;
        start = 1'b1; window = 8'd10;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in = (k == 5) ? 1'b1 : stream[4-k];
            abort = (k == 5);
            #1;
            vectors++;
            if (act !== exp_vec()) begin
                miscompares++; $display("FAIL abort_bit%0d: dut %b model %b", k, act, exp_vec());
            end
            tick();
        end
        abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0 || match_cnt !== 8'd1) begin
                miscompares++; $display("FAIL abort_idle%0d: busy %b done %b cnt %0d required 0 0 1", k, busy, done, match_cnt);
            end
            tick();
        end
        // abort together with start in IDLE: stays idle
        start = 1'b1; abort = 1'b1; window = 8'd5;
        tick();
        start = 1'b0; abort = 1'b0;
        #1;
        vectors++;
        if (act !== exp_vec() || busy !== 1'b0) begin
            miscompares++; $display("FAIL abort_beats_start: dut %b model %b", act, exp_vec());
        end
        // reset in the middle of a window, on a bit that would complete a match
        start = 1'b1; window = 8'd10;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in = (k >= 2);
            reset = (k == 3);
            tick();
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (act !== 18'b0 || act !== exp_vec()) begin
            miscompares++; $display("FAIL reset_in_run: dut %b required all zero", act);
        end
    endtask

    task automatic run_bits(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                            input logic [4:0] stream, input int exp_cnt, input string tag);
        cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
        start = 1'b1; window = 8'd5;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in = stream[4-k];
            #1;
            vectors++;
            if (act !== exp_vec()) begin
                miscompares++; $display("FAIL %s_bit%0d: dut %b model %b", tag, k, act, exp_vec());
            end
            tick();
        end
        #1;
        vectors++;
        if (done !== 1'b1 || match_cnt !== 8'(exp_cnt)) begin
            miscompares++; $display("FAIL %s_end: done %b cnt %0d required 1 %0d", tag, done, match_cnt, exp_cnt);
        end
        tick();
    endtask

    task automatic test_overlap();
        run_bits(8'b101, 4'd3, 1'b1, 5'b10101, 2, "overlap1");
        run_bits(8'b101, 4'd3, 1'b0, 5'b10101, 1, "overlap0");
    endtask

    task automatic test_zero_window();
        start = 1'b1; window = 8'd0;
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL zero_start: busy %b required 0", busy);
        end
        tick();
        start = 1'b0;
        #1;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || match_cnt !== 8'd0) begin
            miscompares++; $display("FAIL zero_window: done %b busy %b cnt %0d required 1 0 0", done, busy, match_cnt);
        end
        tick();
        #1;
        vectors++;
        if (act !== exp_vec()) begin
            miscompares++; $display("FAIL zero_after: dut %b model %b", act, exp_vec());
        end
    endtask

    task automatic test_saturation();
        run_bits(8'b1, 4'd1, 1'b0, 5'b11111, 5, "sat");
        #1;
        vectors++;
        if (match_cnt2 !== 2'd3 || match_cnt !== 8'd5) begin
            miscompares++; $display("FAIL sat_cnt: narrow %0d wide %0d required 3 5", match_cnt2, match_cnt);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; window = 8'd2; in = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; abort = 1'b1; window = 8'd7;   // ignored in DONE
        #1;
        vectors++;
        if (done !== 1'b1 || match_cnt !== 8'd2) begin
            miscompares++; $display("FAIL b2b_done: done %b cnt %0d required 1 2", done, match_cnt);
        end
        tick();
        abort = 1'b0; window = 8'd3; in = 1'b0;
        #1;
        vectors++;
        if (act !== exp_vec() || busy !== 1'b0 || match_cnt !== 8'd2) begin
            miscompares++; $display("FAIL b2b_idle: dut %b model %b", act, exp_vec());
        end
        tick();
        window = 8'd50;                              // start while running is ignored
        for (int k = 0; k < 4; k++) begin
            #1;
            vectors++;
            if (act !== exp_vec()) begin
                miscompares++; $display("FAIL b2b_run%0d: dut %b model %b", k, act, exp_vec());
            end
            tick();
        end
        start = 1'b0;
        #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || match_cnt !== 8'd0) begin
            miscompares++; $display("FAIL b2b_end: done %b busy %b cnt %0d required 0 0 0", done, busy, match_cnt);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset       = ($urandom_range(0, 199) == 0);
            start       = ($urandom_range(0, 5) == 0);
            window      = 8'($urandom_range(0, 20));
            abort       = ($urandom_range(0, 24) == 0);
            in          = 1'($urandom);
            cfg_we      = ($urandom_range(0, 19) == 0);
            cfg_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 9))
                                                      : 4'($urandom_range(1, 3));
            cfg_pattern = 8'($urandom);
            cfg_overlap = 1'($urandom);
            #1;
            vectors++;
            if (act !== exp_vec()) begin
                miscompares++; $display("FAIL random_c%0d: dut %b model %b", c, act, exp_vec());
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        @(negedge clock);
        test_reset();
        test_default_pattern();
        test_cfg_err();
        test_abort();
        test_overlap();
        test_zero_window();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
